// File: rtl/mem_agent_pkg.sv
// Shared AXI constants, campaign state type and helpers for the mem_agent traffic master.
package mem_agent_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] CACHE_VALUE = 4'b0011;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } campaign_state_e;

  // AxSIZE encoding for a full-width beat.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/mem_agent_chan.sv
// Address-issue engine: issue counter, outstanding tracker and IDLE/RUN/DRAIN campaign FSM.
module mem_agent_chan
  import mem_agent_pkg::*;
#(
  parameter int unsigned           AddrWidth      = 32,
  parameter int unsigned           BeatBytes      = 16,
  parameter logic [AddrWidth-1:0]  BaseAddr       = '0,
  parameter int unsigned           NumTxn         = 4096,
  parameter int unsigned           MaxOutstanding = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           data_done_i,
  input  logic                           ready_i,
  input  logic                           resp_i,
  output logic                           valid_o,
  output logic [AddrWidth-1:0]           addr_o,
  output logic [$clog2(NumTxn+1)-1:0]    cnt_o,
  output campaign_state_e                state_o
);

  localparam int unsigned CntW = $clog2(NumTxn + 1);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] NumTxnC = CntW'(NumTxn);
  localparam logic [OutW-1:0] MaxOutC = OutW'(MaxOutstanding);

  campaign_state_e state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] resp_cnt_q;
  logic [OutW-1:0] outst_q;
  logic            issue_hs;
  logic            resp_hs;

  assign valid_o  = (state_q == StRun) && (cnt_q < NumTxnC) && (outst_q < MaxOutC);
  assign issue_hs = valid_o && ready_i;
  // Responses seen while idle (e.g. after a mid-campaign reset) are dropped.
  assign resp_hs  = resp_i && (state_q != StIdle) && (resp_cnt_q < NumTxnC);
  assign addr_o   = BaseAddr + AddrWidth'(cnt_q) * AddrWidth'(BeatBytes);
  assign cnt_o    = cnt_q;
  assign state_o  = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      resp_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            resp_cnt_q <= '0;
            outst_q    <= '0;
          end
        end
        StRun:   if (cnt_q == NumTxnC && data_done_i) state_q <= StDrain;
        StDrain: if (resp_cnt_q == NumTxnC) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (issue_hs) cnt_q <= cnt_q + 1'b1;
      if (resp_hs) resp_cnt_q <= resp_cnt_q + 1'b1;
      if (issue_hs && !resp_hs) begin
        outst_q <= outst_q + 1'b1;
      end else if (!issue_hs && resp_hs) begin
        outst_q <= outst_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_agent_maxi.sv
// Self-driving AXI4 write/read traffic master. Define MEM_AGENT_RDCHK_EN to turn rd_bit_out
// into a sticky read-data checker instead of a parity accumulator.
module mem_agent_maxi
  import mem_agent_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH      = 128,
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter int unsigned            NUM_TXN         = 4096,
  parameter int unsigned            MAX_OUTSTANDING = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  output logic                    M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWLOCK,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [2:0]              M_AXI_AWPROT,
  output logic [3:0]              M_AXI_AWQOS,
  output logic [7:0]              M_AXI_AWUSER,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic [7:0]              M_AXI_WUSER,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic                    M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic [7:0]              M_AXI_BUSER,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic                    M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic [1:0]              M_AXI_ARLOCK,
  output logic [3:0]              M_AXI_ARCACHE,
  output logic [2:0]              M_AXI_ARPROT,
  output logic [3:0]              M_AXI_ARQOS,
  output logic [7:0]              M_AXI_ARUSER,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic                    M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic [7:0]              M_AXI_RUSER,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  input  logic                    r_start_in,
  input  logic                    w_start_in,
  output logic                    rd_bit_out,
  output logic                    b_bit_out
);

  localparam int unsigned CntW = $clog2(NUM_TXN + 1);
  localparam logic [CntW-1:0] NumTxnC = CntW'(NUM_TXN);

  campaign_state_e wr_state;
  campaign_state_e rd_state;
  logic [CntW-1:0] aw_cnt;
  logic [CntW-1:0] ar_cnt;
  logic [CntW-1:0] w_cnt_q;
  logic            b_bit_q;
  logic            rd_bit_q;
  logic            r_hs;
  logic            unused_inputs;

  assign M_AXI_AWID    = 1'b0;
  assign M_AXI_AWLEN   = LEN_SINGLE;
  assign M_AXI_AWSIZE  = axi_size(DATA_WIDTH);
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = CACHE_VALUE;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = 8'h00;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = M_AXI_WVALID;
  assign M_AXI_WUSER   = 8'h00;
  assign M_AXI_BREADY  = 1'b1;
  assign M_AXI_ARID    = 1'b0;
  assign M_AXI_ARLEN   = LEN_SINGLE;
  assign M_AXI_ARSIZE  = axi_size(DATA_WIDTH);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = CACHE_VALUE;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = 8'h00;
  assign M_AXI_RREADY  = 1'b1;

  assign unused_inputs = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RRESP, M_AXI_RUSER, ar_cnt};

  mem_agent_chan #(
    .AddrWidth      (ADDR_WIDTH),
    .BeatBytes      (DATA_WIDTH / 8),
    .BaseAddr       (BASE_ADDR),
    .NumTxn         (NUM_TXN),
    .MaxOutstanding (MAX_OUTSTANDING)
  ) u_wr_chan (
    .clk_i       (ACLK),
    .rst_ni      (ARESETN),
    .start_i     (w_start_in),
    .data_done_i (w_cnt_q == NumTxnC),
    .ready_i     (M_AXI_AWREADY),
    .resp_i      (M_AXI_BVALID),
    .valid_o     (M_AXI_AWVALID),
    .addr_o      (M_AXI_AWADDR),
    .cnt_o       (aw_cnt),
    .state_o     (wr_state)
  );

  mem_agent_chan #(
    .AddrWidth      (ADDR_WIDTH),
    .BeatBytes      (DATA_WIDTH / 8),
    .BaseAddr       (BASE_ADDR),
    .NumTxn         (NUM_TXN),
    .MaxOutstanding (MAX_OUTSTANDING)
  ) u_rd_chan (
    .clk_i       (ACLK),
    .rst_ni      (ARESETN),
    .start_i     (r_start_in),
    .data_done_i (1'b1),
    .ready_i     (M_AXI_ARREADY),
    .resp_i      (M_AXI_RVALID && M_AXI_RLAST),
    .valid_o     (M_AXI_ARVALID),
    .addr_o      (M_AXI_ARADDR),
    .cnt_o       (ar_cnt),
    .state_o     (rd_state)
  );

  // W may run at most one beat ahead of the accepted AW count.
  assign M_AXI_WVALID = (wr_state == StRun) && (w_cnt_q < NumTxnC) && (w_cnt_q <= aw_cnt);
  assign M_AXI_WDATA  = DATA_WIDTH'(w_cnt_q);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_cnt_q <= '0;
      b_bit_q <= 1'b0;
    end else begin
      if (wr_state == StIdle && w_start_in) begin
        w_cnt_q <= '0;
      end else if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_cnt_q <= w_cnt_q + 1'b1;
      end
      if (M_AXI_BVALID && wr_state != StIdle) b_bit_q <= b_bit_q ^ ~(|M_AXI_BRESP);
    end
  end

  assign r_hs = M_AXI_RVALID && (rd_state != StIdle);

`ifdef MEM_AGENT_RDCHK_EN
  logic [CntW-1:0] exp_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      exp_q    <= '0;
      rd_bit_q <= 1'b0;
    end else if (rd_state == StIdle && r_start_in) begin
      exp_q <= '0;
    end else if (r_hs) begin
      exp_q <= exp_q + 1'b1;
      if (M_AXI_RDATA != DATA_WIDTH'(exp_q) || M_AXI_RRESP[1]) rd_bit_q <= 1'b1;
    end
  end
`else
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_bit_q <= 1'b0;
    end else if (r_hs) begin
      rd_bit_q <= rd_bit_q ^ (^M_AXI_RDATA);
    end
  end
`endif

  assign rd_bit_out = rd_bit_q;
  assign b_bit_out  = b_bit_q;

endmodule

// File: tb/tb_mem_agent_maxi.sv
// Directed bench for mem_agent_maxi: write/read campaigns, READY stalls, outstanding limit,
// mid-campaign reset and read-data corruption.
module tb_mem_agent_maxi;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 32;
  localparam int NT = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            awid, awlock, awvalid, wlast, wvalid, bready, arid, arvalid, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, awuser, wuser, arlen, aruser;
  logic [2:0]      awsize, awprot, arsize, arprot;
  logic [1:0]      awburst, arburst, arlock;
  logic [3:0]      awcache, awqos, arcache, arqos;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            rd_bit, b_bit;

  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic          bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic [DW-1:0] rdata = '0;
  logic          r_start = 1'b0, w_start = 1'b0;

  mem_agent_maxi u_dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .M_AXI_AWID    (awid),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWLEN   (awlen),
    .M_AXI_AWSIZE  (awsize),
    .M_AXI_AWBURST (awburst),
    .M_AXI_AWLOCK  (awlock),
    .M_AXI_AWCACHE (awcache),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWQOS   (awqos),
    .M_AXI_AWUSER  (awuser),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WLAST   (wlast),
    .M_AXI_WUSER   (wuser),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BID     (1'b0),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BUSER   (8'h00),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARID    (arid),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARLEN   (arlen),
    .M_AXI_ARSIZE  (arsize),
    .M_AXI_ARBURST (arburst),
    .M_AXI_ARLOCK  (arlock),
    .M_AXI_ARCACHE (arcache),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARQOS   (arqos),
    .M_AXI_ARUSER  (aruser),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RID     (1'b0),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (2'b00),
    .M_AXI_RLAST   (rlast),
    .M_AXI_RUSER   (8'h00),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .r_start_in    (r_start),
    .w_start_in    (w_start),
    .rd_bit_out    (rd_bit),
    .b_bit_out     (b_bit)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model and monitor: one process owns all counters and response queues.
  int cyc = 0;
  int aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
  int addr_err = 0, wdata_err = 0, araddr_err = 0, max_out = 0;
  int b_sent = 0, r_sent = 0;
  int bdelay = 20;
  int bq[$];
  int rq[$];
  bit clr = 1'b0, stall_aw = 1'b0, stall_ar = 1'b0, corrupt_en = 1'b0;

  always begin
    @(posedge clk);
    cyc++;
    if (clr) begin
      aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
      addr_err = 0; wdata_err = 0; araddr_err = 0; max_out = 0; b_sent = 0; r_sent = 0;
    end else begin
      if (awvalid && awready) begin
        if (awaddr !== AW'(aw_seen * 16)) addr_err++;
        aw_seen++;
        bq.push_back(cyc + bdelay);
      end
      if (wvalid && wready) begin
        if (wdata !== DW'(w_seen) || wlast !== 1'b1 || wstrb !== '1) wdata_err++;
        w_seen++;
      end
      if (bvalid && bready) b_seen++;
      if (aw_seen - b_seen > max_out) max_out = aw_seen - b_seen;
      if (arvalid && arready) begin
        if (araddr !== AW'(ar_seen * 16)) araddr_err++;
        ar_seen++;
        rq.push_back(cyc + 10);
      end
      if (rvalid && rready) r_seen++;
    end
    #1;
    awready = !stall_aw;
    wready  = 1'b1;
    arready = !stall_ar;
    if (bq.size() > 0 && bq[0] <= cyc) begin
      void'(bq.pop_front());
      bvalid = 1'b1;
      bresp  = (b_sent == 7) ? 2'b10 : 2'b00;
      b_sent++;
    end else begin
      bvalid = 1'b0;
      bresp  = 2'b00;
    end
    if (rq.size() > 0 && rq[0] <= cyc) begin
      void'(rq.pop_front());
      rvalid = 1'b1;
      rlast  = 1'b1;
      rdata  = DW'(r_sent) ^ DW'(corrupt_en && r_sent == 5);
      r_sent++;
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rdata  = '0;
    end
  end

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [AW-1:0] held_addr;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_wvalid", wvalid, 0);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_rd_bit", rd_bit, 0);
    check_eq("rst_b_bit", b_bit, 0);
    check_eq("bready", bready, 1);
    check_eq("rready", rready, 1);
    check_eq("awsize", awsize, 4);
    check_eq("awburst", awburst, 1);
    check_eq("awcache", awcache, 3);
    check_eq("awlen", awlen, 0);
    check_eq("wstrb", wstrb, 16'hFFFF);
    check_eq("arlock", arlock, 0);

    // Write campaign with an AW stall and an ignored second start.
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    for (int i = 0; i < 2000 && aw_seen < 100; i++) @(negedge clk);
    check_eq("wr_start_timeout", aw_seen >= 100, 1);
    stall_aw = 1'b1;
    repeat (3) @(negedge clk);
    held_addr = awaddr;
    check_eq("aw_stall_addr", held_addr, AW'(aw_seen * 16));
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    repeat (1000) @(negedge clk);
    check_eq("aw_stall_valid", awvalid, 1);
    check_eq("aw_stall_hold", awaddr, AW'(aw_seen * 16));
    stall_aw = 1'b0;
    for (int i = 0; i < 20000 && b_seen < NT; i++) @(negedge clk);
    check_eq("wr_done_timeout", b_seen >= NT, 1);
    repeat (40) @(negedge clk);
    check_eq("aw_count", aw_seen, NT);
    check_eq("w_count", w_seen, NT);
    check_eq("b_count", b_seen, NT);
    check_eq("aw_addr_seq", addr_err, 0);
    check_eq("wdata_seq", wdata_err, 0);
    check_eq("outst_window", (max_out >= 20 && max_out <= 32), 1);
    check_eq("wr_idle_awvalid", awvalid, 0);
    check_eq("wr_idle_wvalid", wvalid, 0);
    check_eq("b_bit_final", b_bit, 1);

    // Read campaign with an AR stall.
    pulse_clr();
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    for (int i = 0; i < 2000 && ar_seen < 200; i++) @(negedge clk);
    check_eq("rd_start_timeout", ar_seen >= 200, 1);
    stall_ar = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ar_stall_addr", araddr, AW'(ar_seen * 16));
    check_eq("arlen", arlen, 0);
    check_eq("arsize", arsize, 4);
    repeat (1000) @(negedge clk);
    check_eq("ar_stall_valid", arvalid, 1);
    check_eq("ar_stall_hold", araddr, AW'(ar_seen * 16));
    stall_ar = 1'b0;
    for (int i = 0; i < 20000 && r_seen < NT; i++) @(negedge clk);
    check_eq("rd_done_timeout", r_seen >= NT, 1);
    repeat (20) @(negedge clk);
    check_eq("ar_count", ar_seen, NT);
    check_eq("r_count", r_seen, NT);
    check_eq("ar_addr_seq", araddr_err, 0);
    check_eq("rd_idle_arvalid", arvalid, 0);
    check_eq("rd_bit_clean", rd_bit, 0);

    // Restart after IDLE with slow B: outstanding must cap at 32, then reset mid-campaign.
    pulse_clr();
    bdelay = 60;
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("restart_issued", aw_seen > 32, 1);
    check_eq("restart_addr_seq", addr_err, 0);
    check_eq("outst_cap", max_out, 32);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_awvalid", awvalid, 0);
    check_eq("midrst_wvalid", wvalid, 0);
    repeat (100) @(negedge clk);
    check_eq("midrst_stale_b_awvalid", awvalid, 0);
    check_eq("midrst_b_bit", b_bit, 0);
    bdelay = 20;

    // Read campaign with beat 5 corrupted (bit 0 flipped).
    pulse_clr();
    corrupt_en = 1'b1;
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    for (int i = 0; i < 2000 && r_seen < 10; i++) @(negedge clk);
    check_eq("corrupt_start_timeout", r_seen >= 10, 1);
`ifdef MEM_AGENT_RDCHK_EN
    check_eq("rdchk_flag_mid", rd_bit, 1);
`endif
    for (int i = 0; i < 20000 && r_seen < NT; i++) @(negedge clk);
    check_eq("corrupt_done_timeout", r_seen >= NT, 1);
    repeat (20) @(negedge clk);
    check_eq("corrupt_r_count", r_seen, NT);
    check_eq("rd_bit_corrupt", rd_bit, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
